// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers.
// Define UART_ARB_TAG_EN to precede every data byte with a source tag frame.
module uart_tx_arbiter #(
   parameter int NREQ = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   gnt,
   output logic              busy,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_done_tick
);

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] START      = 3'd1;
   localparam logic [2:0] WAIT       = 3'd2;
`ifdef UART_ARB_TAG_EN
   localparam logic [2:0] TAG_WAIT   = 3'd3;
   localparam logic [2:0] DATA_START = 3'd4;
`endif

   logic [2:0]      state;
   logic [2:0]      last;
   logic            found;
   logic [2:0]      winner;
   logic [7:0]      win_byte;
   logic [NREQ-1:0] win_onehot;
   int              idx;
`ifdef UART_ARB_TAG_EN
   logic [7:0]      hold;
`endif

   // Search from last+1 upward, wrapping at NREQ-1; first pending request wins.
   always_comb begin
      found      = 1'b0;
      winner     = last;
      win_byte   = 8'h00;
      win_onehot = '0;
      idx        = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last) + k) % NREQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            winner     = idx[2:0];
            win_byte   = req_data[8*idx +: 8];
            win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         last     <= 3'(NREQ-1);
         gnt      <= '0;
         busy     <= 1'b0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
`ifdef UART_ARB_TAG_EN
         hold     <= 8'h00;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  gnt      <= win_onehot;
                  tx_start <= 1'b1;
                  busy     <= 1'b1;
                  last     <= winner;
                  state    <= START;
`ifdef UART_ARB_TAG_EN
                  tx_data  <= {5'b10100, winner};
                  hold     <= win_byte;
`else
                  tx_data  <= win_byte;
`endif
               end
            end
            START: begin
               gnt      <= '0;
               tx_start <= 1'b0;
`ifdef UART_ARB_TAG_EN
               state    <= TAG_WAIT;
`else
               state    <= WAIT;
`endif
            end
`ifdef UART_ARB_TAG_EN
            TAG_WAIT: begin
               if (tx_done_tick) begin
                  tx_data  <= hold;
                  tx_start <= 1'b1;
                  state    <= DATA_START;
               end
            end
            DATA_START: begin
               tx_start <= 1'b0;
               state    <= WAIT;
            end
`endif
            WAIT: begin
               if (tx_done_tick) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               gnt      <= '0;
               tx_start <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NREQ=4); frames are matched against
// an expected queue of {gnt, tx_data} entries pushed when requests are driven.
module tb_uart_tx_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  gnt;
   logic        busy;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_done_tick;

   logic [11:0] exp_q[$];
   logic [11:0] exp_e;
   logic [7:0]  cur_data;
   int          tests;
   int          fails;

   uart_tx_arbiter #(.NREQ(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .req_data     (req_data),
      .gnt          (gnt),
      .busy         (busy),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .tx_done_tick (tx_done_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push_req(input int id, input logic [7:0] b);
      logic [3:0] oh;
      logic [2:0] id3;
      oh  = 4'b0001 << id;
      id3 = 3'(id);
`ifdef UART_ARB_TAG_EN
      exp_q.push_back({oh, 5'b10100, id3});
      exp_q.push_back({4'b0000, b});
`else
      exp_q.push_back({oh, b});
`endif
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset        = 1'b1;
      req          = '0;
      tx_done_tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Wait for tx_start, check the frame against the scoreboard, then apply next req.
   task automatic wait_frame(input logic [3:0] req_next, input logic [31:0] data_next,
                             input bit done_in_start);
      int t;
      t = 0;
      while (tx_start !== 1'b1 && t < 40) begin
         @(negedge clk);
         t++;
      end
      tests++;
      if (tx_start !== 1'b1) begin
         fails++;
         $display("FAIL start_timeout: tx_start=%b required 1 within 40 cycles", tx_start);
      end else if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_frame: gnt=%b tx_data=%h, scoreboard empty", gnt, tx_data);
      end else begin
         exp_e = exp_q.pop_front();
         if ({gnt, tx_data} !== exp_e) begin
            fails++;
            $display("FAIL frame: gnt=%b tx_data=%h required gnt=%b tx_data=%h",
                     gnt, tx_data, exp_e[11:8], exp_e[7:0]);
         end
         tests++;
         if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_at_start: busy=%b required 1", busy);
         end
      end
      cur_data = tx_data;
      req      = req_next;
      req_data = data_next;
      if (done_in_start) tx_done_tick = 1'b1;
   endtask

   // Hold the frame for a few cycles, then complete it with a done pulse.
   task automatic finish_frame(input bit expect_idle);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         tx_done_tick = 1'b0;
         tests++;
         if (tx_start !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b1 || tx_data !== cur_data) begin
            fails++;
            $display("FAIL hold: tx_start=%b gnt=%b busy=%b tx_data=%h required 0 0000 1 %h",
                     tx_start, gnt, busy, tx_data, cur_data);
         end
      end
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
      tests++;
      if (busy !== (expect_idle ? 1'b0 : 1'b1)) begin
         fails++;
         $display("FAIL busy_after_done: busy=%b required %b", busy, !expect_idle);
      end
   endtask

   task automatic serve(input logic [3:0] req_next, input logic [31:0] data_next,
                        input bit done_in_start);
      wait_frame(req_next, data_next, done_in_start);
`ifdef UART_ARB_TAG_EN
      finish_frame(1'b0);
      wait_frame(req_next, data_next, 1'b0);
`endif
      finish_frame(1'b1);
   endtask

   task automatic test_reset();
      apply_reset();
      tests++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00) begin
         fails++;
         $display("FAIL reset_values: gnt=%b busy=%b tx_start=%b tx_data=%h required 0000 0 0 00",
                  gnt, busy, tx_start, tx_data);
      end
   endtask

   task automatic test_single();
      req_data = 32'h0000_0055;
      req      = 4'b0001;
      push_req(0, 8'h55);
      @(negedge clk);
      tests++;
      if (tx_start !== 1'b1 || gnt !== 4'b0001) begin
         fails++;
         $display("FAIL single_latency: tx_start=%b gnt=%b required 1 0001 one cycle after req",
                  tx_start, gnt);
      end
      serve(4'b0000, 32'h0000_0055, 1'b0);
   endtask

   task automatic test_round_robin();
      apply_reset();
      req_data = 32'h1312_1110;
      req      = 4'b1111;
      for (int i = 0; i < 5; i++) push_req(i % 4, 8'h10 + 8'(i % 4));
      for (int i = 0; i < 5; i++) serve((i < 4) ? 4'b1111 : 4'b0000, 32'h1312_1110, 1'b0);
   endtask

   task automatic test_wrap();
      apply_reset();
      req_data = 32'h3300_0000;
      req      = 4'b1000;
      push_req(3, 8'h33);
      push_req(2, 8'h22);
      serve(4'b1100, 32'h3322_0000, 1'b0);
      serve(4'b0000, 32'h3322_0000, 1'b0);
      // last is now 2: requester 3 wins before 0, then the search wraps to 0
      req_data = 32'h3300_00a0;
      req      = 4'b1001;
      push_req(3, 8'h33);
      push_req(0, 8'ha0);
      serve(4'b0001, 32'h3300_00a0, 1'b0);
      serve(4'b0000, 32'h3300_00a0, 1'b0);
   endtask

   task automatic test_done_ignored();
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tests++;
         if (busy !== 1'b0 || tx_start !== 1'b0 || gnt !== 4'b0000) begin
            fails++;
            $display("FAIL done_in_idle: busy=%b tx_start=%b gnt=%b required 0 0 0000",
                     busy, tx_start, gnt);
         end
         @(negedge clk);
      end
      req_data = 32'h0000_6b00;
      req      = 4'b0010;
      push_req(1, 8'h6b);
      serve(4'b0000, 32'h0000_6b00, 1'b1);
   endtask

   task automatic test_reset_in_wait();
      req_data = 32'h0081_0000;
      req      = 4'b0100;
      push_req(2, 8'h81);
      wait_frame(4'b0000, 32'h0081_0000, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tests++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00) begin
         fails++;
         $display("FAIL reset_in_wait: gnt=%b busy=%b tx_start=%b tx_data=%h required 0000 0 0 00",
                  gnt, busy, tx_start, tx_data);
      end
      exp_q.delete();
      req_data = 32'h4443_4241;
      req      = 4'b1111;
      push_req(0, 8'h41);
      serve(4'b0000, 32'h4443_4241, 1'b0);
   endtask

`ifdef UART_ARB_TAG_EN
   task automatic test_tag();
      apply_reset();
      req_data = 32'h00a7_0000;
      req      = 4'b0100;
      exp_q.push_back({4'b0100, 8'ha2});
      exp_q.push_back({4'b0000, 8'ha7});
      wait_frame(4'b0000, 32'h00a7_0000, 1'b0);
      finish_frame(1'b0);
      wait_frame(4'b0000, 32'h00a7_0000, 1'b0);
      finish_frame(1'b1);
   endtask
`endif

   initial begin
      tests        = 0;
      fails        = 0;
      reset        = 1'b1;
      req          = '0;
      req_data     = '0;
      tx_done_tick = 1'b0;
      cur_data     = 8'h00;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_done_ignored();
      test_reset_in_wait();
`ifdef UART_ARB_TAG_EN
      test_tag();
`endif
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among up to eight byte-producing requesters, such as pipeline debug taps and a command responder. It sits directly in front of the transmitter, selects one pending requester, acknowledges the byte and drives the transmitter's start strobe and data bus. It then holds off further grants until the transmitter reports frame completion. When built with the tag option, each byte is preceded by a tag byte that identifies its source.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  NREQ  request i pending; held high with its byte until granted
- req_data  input  8*NREQ  packed bytes; requester i at [8i+7:8i]
- gnt  output  NREQ  one-hot, one-cycle acknowledge; byte of requester i captured
- busy  output  1  high whenever state is not IDLE
- tx_start  output  1  one-cycle start strobe to transmitter
- tx_data  output  8  byte presented to transmitter; stable while tx_start is high
- tx_done_tick  input  1  one-cycle frame-complete pulse from transmitter

## Operation
- States without tag: IDLE, START, WAIT.
- IDLE:
  - If any req bit is set, pick the winner round-robin, searching from last+1 upward and wrapping at NREQ-1.
  - On that edge: gnt <= onehot(winner), tx_data <= winner's byte, tx_start <= 1, last <= winner, state <= START.
- START: tx_start and gnt are high for exactly this cycle, then both clear. state <= WAIT.
- WAIT: tx_data is held. On tx_done_tick, state <= IDLE.
- tx_done_tick is ignored in IDLE and START.
- Requests not granted in a cycle stay pending. There is no starvation: a continuously asserted requester is served within NREQ frames.
- Requester contract:
  - Keep req high and req_data stable until gnt is seen.
  - Deassert req, or present the next byte, on the cycle after gnt.
  - A second grant to the same requester cannot occur before WAIT has completed.
- req bits at index >= NREQ do not exist. Winner index width is 3 bits.
- Reset mid-frame:
  - The arbiter returns to IDLE at once.
  - A frame already started in the transmitter is not cancelled. The next tx_start issued while the transmitter is still busy is ignored by it, and that byte is lost.
  - The system must reset both blocks together.

## Timing
- Reset values: gnt=0, busy=0, tx_start=0, tx_data=8'h00, state=IDLE, last=NREQ-1 so requester 0 wins first.
- req sampled high at edge k → gnt and tx_start high in cycle k+1 (one cycle) → busy high from cycle k+1.
- tx_done_tick in cycle m → IDLE from cycle m+1 → the earliest next tx_start is in cycle m+2.
- All outputs are registered. There is no combinational path from req or tx_done_tick to any output.

## Configuration
- Macro UART_ARB_TAG_EN.
- Defined:
  - States are IDLE, TAG_START, TAG_WAIT, DATA_START, WAIT.
  - On the IDLE grant, tx_data <= {5'b10100, winner[2:0]}, the data byte is latched into an internal holding register, and gnt pulses in the TAG_START cycle.
  - TAG_WAIT goes to DATA_START on tx_done_tick.
  - DATA_START drives tx_data <= held byte with tx_start=1 for one cycle, then goes to WAIT.
  - Two frames are sent per grant.
- Undefined: the three-state machine above; one frame per grant and no holding register.

## Test plan
- Reset, then req=4'b0001, byte0=8'h55 → gnt=0001 and tx_start pulse one cycle after req, tx_data=8'h55, busy high until the cycle after tx_done_tick.
- req=4'b1111 held continuously, bytes 8'h10..8'h13 → grant order 0,1,2,3,0 with one frame per grant, and no tx_start before the preceding tx_done_tick.
- Only requester 3 active, with req 2 raised mid-frame → req 2 is granted next, and last wraps correctly from 3 to 0.
- tx_done_tick pulsed while in IDLE or START → ignored; no extra grant, no state change.
- Reset asserted during WAIT → next cycle gnt=0, tx_start=0, busy=0, tx_data=8'h00; a subsequent req is granted to requester 0 first.
- With UART_ARB_TAG_EN, requester 2 sends 8'hA7 → frames 8'hA2 then 8'hA7, and the single gnt pulse coincides with the first tx_start.
